afifo_level: RTL and testbench

AFIFO_LEVEL -- requirements
Module: afifo_level

---
 rtl/afifo_level.sv | 193 +++++++++++++++++++
 tb/tb_afifo_level.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_level.sv
// Dual-clock FWFT FIFO with Gray-pointer crossing, registered level reports and almost flags.
// Define AFIFO_LEVEL_ERRFLAG_EN to add the sticky woverflow/runderflow error outputs.
module afifo_level #(
   parameter int Width       = 12,
   parameter int Depth       = 16,
   parameter int SyncStages  = 2,
   parameter int AlmostFull  = Depth - 2,
   parameter int AlmostEmpty = 2
) (
   input  logic                     rclk,
   input  logic                     dirclr,
   input  logic                     wclk,
   input  logic                     w,
   input  logic [Width-1:0]         wd,
   output logic                     wfull,
   output logic [$clog2(Depth):0]   wlevel,
   output logic                     walmostfull,
   input  logic                     r,
   output logic [Width-1:0]         rd,
   output logic                     rempty,
   output logic [$clog2(Depth):0]   rlevel,
   output logic                     ralmostempty
`ifdef AFIFO_LEVEL_ERRFLAG_EN
   ,
   output logic                     woverflow,
   output logic                     runderflow
`endif
);

   localparam int AW = $clog2(Depth);
   localparam logic [AW:0] AFullLvl  = (AW+1)'(AlmostFull);
   localparam logic [AW:0] AEmptyLvl = (AW+1)'(AlmostEmpty);

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [Width-1:0] mem [Depth];

   logic [1:0]  wRstSync_q;
   logic [AW:0] wBin_q, wBin_d, wGray_q, wGray_d;
   logic [AW:0] wLevel_q, wLevel_d;
   logic        wFull_q, wFull_d, wAFull_q, wAFull_d;
   logic [AW:0] rGraySync_q [SyncStages];

   logic [1:0]  rRstSync_q;
   logic [AW:0] rBin_q, rBin_d, rGray_q, rGray_d;
   logic [AW:0] rLevel_q, rLevel_d;
   logic        rEmpty_q, rEmpty_d, rAEmpty_q, rAEmpty_d;
   logic [AW:0] wGraySync_q [SyncStages];

   logic        wPush, rPop;
   logic [AW:0] wBinNext, wGrayNext, rGrayW;
   logic [AW:0] rBinNext, rGrayNext, wGrayR;

   // Write-domain reset release; stage 0 is used as "reset next cycle" so wfull drops on the 2nd edge
   always_ff @(posedge wclk or posedge dirclr) begin
      if (dirclr) wRstSync_q <= 2'b11;
      else        wRstSync_q <= {wRstSync_q[0], 1'b0};
   end

   always_ff @(posedge wclk or posedge dirclr) begin
      if (dirclr) begin
         for (int i = 0; i < SyncStages; i++) rGraySync_q[i] <= '0;
      end else begin
         rGraySync_q[0] <= rGray_q;
         for (int i = 1; i < SyncStages; i++) rGraySync_q[i] <= rGraySync_q[i-1];
      end
   end

   assign wPush     = w & ~wFull_q & ~wRstSync_q[1];
   assign wBinNext  = wBin_q + (AW+1)'(wPush);
   assign wGrayNext = bin2gray(wBinNext);
   assign rGrayW    = rGraySync_q[SyncStages-1];

   always_comb begin
      wBin_d   = wBinNext;
      wGray_d  = wGrayNext;
      wFull_d  = (wGrayNext == {~rGrayW[AW:AW-1], rGrayW[AW-2:0]});
      wLevel_d = wBinNext - gray2bin(rGrayW);
      wAFull_d = (wLevel_d >= AFullLvl);
      if (wRstSync_q[0]) begin
         wFull_d  = 1'b1;
         wLevel_d = '0;
         wAFull_d = 1'b0;
      end
   end

   always_ff @(posedge wclk or posedge dirclr) begin
      if (dirclr) begin
         wBin_q   <= '0;
         wGray_q  <= '0;
         wLevel_q <= '0;
         wFull_q  <= 1'b1;
         wAFull_q <= 1'b0;
      end else begin
         wBin_q   <= wBin_d;
         wGray_q  <= wGray_d;
         wLevel_q <= wLevel_d;
         wFull_q  <= wFull_d;
         wAFull_q <= wAFull_d;
      end
   end

   always_ff @(posedge wclk) begin
      if (wPush) mem[wBin_q[AW-1:0]] <= wd;
   end

   // Read-domain reset release mirrors the write side
   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) rRstSync_q <= 2'b11;
      else        rRstSync_q <= {rRstSync_q[0], 1'b0};
   end

   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         for (int i = 0; i < SyncStages; i++) wGraySync_q[i] <= '0;
      end else begin
         wGraySync_q[0] <= wGray_q;
         for (int i = 1; i < SyncStages; i++) wGraySync_q[i] <= wGraySync_q[i-1];
      end
   end

   assign rPop      = r & ~rEmpty_q & ~rRstSync_q[1];
   assign rBinNext  = rBin_q + (AW+1)'(rPop);
   assign rGrayNext = bin2gray(rBinNext);
   assign wGrayR    = wGraySync_q[SyncStages-1];

   always_comb begin
      rBin_d    = rBinNext;
      rGray_d   = rGrayNext;
      rEmpty_d  = (rGrayNext == wGrayR);
      rLevel_d  = gray2bin(wGrayR) - rBinNext;
      rAEmpty_d = (rLevel_d <= AEmptyLvl);
      if (rRstSync_q[0]) begin
         rEmpty_d  = 1'b1;
         rLevel_d  = '0;
         rAEmpty_d = 1'b1;
      end
   end

   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr) begin
         rBin_q    <= '0;
         rGray_q   <= '0;
         rLevel_q  <= '0;
         rEmpty_q  <= 1'b1;
         rAEmpty_q <= 1'b1;
      end else begin
         rBin_q    <= rBin_d;
         rGray_q   <= rGray_d;
         rLevel_q  <= rLevel_d;
         rEmpty_q  <= rEmpty_d;
         rAEmpty_q <= rAEmpty_d;
      end
   end

   // The head word is stable long before its pointer crosses, so a direct array read is safe
   assign rd           = rEmpty_q ? '0 : mem[rBin_q[AW-1:0]];
   assign rempty       = rEmpty_q;
   assign rlevel       = rLevel_q;
   assign ralmostempty = rAEmpty_q;
   assign wfull        = wFull_q;
   assign wlevel       = wLevel_q;
   assign walmostfull  = wAFull_q;

`ifdef AFIFO_LEVEL_ERRFLAG_EN
   logic wOverflow_q, rUnderflow_q;

   always_ff @(posedge wclk or posedge dirclr) begin
      if (dirclr)                             wOverflow_q <= 1'b0;
      else if (w & wFull_q & ~wRstSync_q[1])  wOverflow_q <= 1'b1;
   end

   always_ff @(posedge rclk or posedge dirclr) begin
      if (dirclr)                             rUnderflow_q <= 1'b0;
      else if (r & rEmpty_q & ~rRstSync_q[1]) rUnderflow_q <= 1'b1;
   end

   assign woverflow  = wOverflow_q;
   assign runderflow = rUnderflow_q;
`endif

endmodule

// File: tb/tb_afifo_level.sv
// Bench for afifo_level: directed reset/fill/underflow steps plus randomized and rate-skewed streams
// checked against a queue model. Delay unit is taken as 100 ps (Ns = 10 units).
module tb_afifo_level;

   localparam int Width          = 12;
   localparam int Depth          = 16;
   localparam int Ns             = 10;
   localparam int NumStreamWords = 1500;
   localparam int StallLimit     = 2000;

   logic             rclk = 1'b0, wclk = 1'b0, dirclr = 1'b0;
   logic             w = 1'b0, r = 1'b0;
   logic [Width-1:0] wd = '0;
   logic             wfull, walmostfull, rempty, ralmostempty;
   logic [4:0]       wlevel, rlevel;
   logic [Width-1:0] rd;
`ifdef AFIFO_LEVEL_ERRFLAG_EN
   logic             woverflow, runderflow;
`endif

   int wHalf = 5 * Ns;
   int rHalf = 4 * Ns;
   int testsRun = 0;
   int failCount = 0;
   int rEdgeCount = 0;
   int streamPopped = 0;

   logic [Width-1:0] model [$];
   int               stamps [$];

   afifo_level #(.Width(12), .Depth(16), .SyncStages(2), .AlmostFull(14), .AlmostEmpty(2)) dut (
      .rclk(rclk), .dirclr(dirclr), .wclk(wclk),
      .w(w), .wd(wd), .wfull(wfull), .wlevel(wlevel), .walmostfull(walmostfull),
      .r(r), .rd(rd), .rempty(rempty), .rlevel(rlevel), .ralmostempty(ralmostempty)
`ifdef AFIFO_LEVEL_ERRFLAG_EN
      , .woverflow(woverflow), .runderflow(runderflow)
`endif
   );

   // wclk edges land on multiples of 10 units, rclk edges half-way between, so they never coincide
   initial forever #(wHalf) wclk = ~wclk;
   initial begin
      #(Ns / 2);
      forever #(rHalf) rclk = ~rclk;
   end
   always @(posedge rclk) rEdgeCount++;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      assert (got === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic writeWord(input logic [Width-1:0] d, output bit accepted);
      @(negedge wclk);
      accepted = !wfull;
      w = 1'b1;
      wd = d;
      @(posedge wclk);
      #1;
      w = 1'b0;
   endtask

   task automatic readWait(output logic [Width-1:0] d, output bit got);
      got = 1'b0;
      d = '0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge rclk);
         if (!rempty) begin
            d = rd;
            got = 1'b1;
            r = 1'b1;
            @(posedge rclk);
            #1;
            r = 1'b0;
         end
      end
   endtask

   task automatic pulseReset();
      @(negedge wclk);
      dirclr = 1'b1;
      #1;
      checkOutput("rst_rempty", rempty, 1);
      checkOutput("rst_rd", rd, 0);
      checkOutput("rst_rlevel", rlevel, 0);
      checkOutput("rst_ralmostempty", ralmostempty, 1);
      checkOutput("rst_wfull", wfull, 1);
      checkOutput("rst_wlevel", wlevel, 0);
      checkOutput("rst_walmostfull", walmostfull, 0);
      @(negedge wclk);
      dirclr = 1'b0;
   endtask

   task automatic applyStimulus(input int n, input bit randData, input bit randStrobe, input bit checkLat);
      model.delete();
      stamps.delete();
      streamPopped = 0;
      fork
         begin : writer
            int idx;
            int stall;
            bit drive;
            bit acc;
            idx = 0;
            stall = 0;
            while (idx < n) begin
               @(negedge wclk);
               testsRun++;
               assert (wlevel <= 5'd16 && int'(wlevel) >= model.size()) else begin
                  failCount++;
                  $error("FAIL wlevel_bound: observed %0d expected %0d..16", wlevel, model.size());
               end
               checkOutput("wfull_vs_wlevel", wfull, (wlevel == 5'd16));
               drive = randStrobe ? ($urandom_range(3) != 0) : 1'b1;
               acc = drive && !wfull;
               w = drive;
               wd = randData ? Width'($urandom) : Width'(idx);
               @(posedge wclk);
               if (acc) begin
                  model.push_back(wd);
                  stamps.push_back(rEdgeCount);
                  idx++;
                  stall = 0;
               end else begin
                  stall++;
                  if (stall > StallLimit) begin
                     checkOutput("writer_stall_budget", stall, 0);
                     break;
                  end
               end
            end
            #1;
            w = 1'b0;
         end
         begin : reader
            int idle;
            int lat;
            bit seen;
            bit rr;
            bit acc;
            idle = 0;
            seen = 1'b0;
            while (streamPopped < n) begin
               @(negedge rclk);
               if (model.size() == 0) begin
                  checkOutput("rempty_when_drained", rempty, 1);
               end else if (!rempty) begin
                  checkOutput("stream_rd", rd, model[0]);
                  testsRun++;
                  assert (rlevel >= 5'd1 && int'(rlevel) <= model.size()) else begin
                     failCount++;
                     $error("FAIL rlevel_bound: observed %0d expected 1..%0d", rlevel, model.size());
                  end
                  if (checkLat && !seen) begin
                     lat = rEdgeCount - stamps[0];
                     testsRun++;
                     assert (lat <= 4) else begin
                        failCount++;
                        $error("FAIL rempty_latency: observed %0d edges required <= 4", lat);
                     end
                     seen = 1'b1;
                  end
               end
               if (rempty) begin
                  checkOutput("empty_rd_zero", rd, 0);
                  checkOutput("empty_rlevel_zero", rlevel, 0);
               end
               rr = randStrobe ? ($urandom_range(2) != 0) : 1'b1;
               acc = rr && !rempty;
               r = rr;
               @(posedge rclk);
               if (acc && model.size() > 0) begin
                  void'(model.pop_front());
                  void'(stamps.pop_front());
                  streamPopped++;
                  seen = 1'b0;
                  idle = 0;
               end else begin
                  idle++;
                  if (idle > StallLimit) begin
                     checkOutput("reader_idle_budget", idle, 0);
                     break;
                  end
               end
            end
            #1;
            r = 1'b0;
         end
      join
      checkOutput("stream_popped", streamPopped, n);
      checkOutput("stream_model_empty", model.size(), 0);
   endtask

   initial begin
      logic [Width-1:0] data;
      bit               ok;

      // Reset behaviour and wfull release timing
      #2;
      dirclr = 1'b1;
      #(3 * Ns);
      checkOutput("rst_rempty", rempty, 1);
      checkOutput("rst_rd", rd, 0);
      checkOutput("rst_rlevel", rlevel, 0);
      checkOutput("rst_ralmostempty", ralmostempty, 1);
      checkOutput("rst_wfull", wfull, 1);
      checkOutput("rst_wlevel", wlevel, 0);
      checkOutput("rst_walmostfull", walmostfull, 0);
      @(negedge wclk);
      dirclr = 1'b0;
      @(posedge wclk);
      #1;
      checkOutput("wfull_after_edge1", wfull, 1);
      @(posedge wclk);
      #1;
      checkOutput("wfull_after_edge2", wfull, 0);
      repeat (3) @(posedge rclk);
      #1;
      checkOutput("idle_rempty", rempty, 1);
      checkOutput("idle_rd", rd, 0);
      checkOutput("idle_rlevel", rlevel, 0);

      // Fill to capacity, drop an overflow write, drain in order
      for (int i = 0; i < 16; i++) begin
         writeWord(Width'(i), ok);
         checkOutput("fill_accepted", ok, 1);
         checkOutput("fill_wlevel", wlevel, i + 1);
         checkOutput("fill_walmostfull", walmostfull, (i + 1 >= 14));
         checkOutput("fill_wfull", wfull, (i == 15));
      end
      writeWord(12'hABC, ok);
      checkOutput("overflow_refused", ok, 0);
      checkOutput("overflow_wlevel", wlevel, 16);
      checkOutput("overflow_wfull", wfull, 1);
`ifdef AFIFO_LEVEL_ERRFLAG_EN
      checkOutput("woverflow_set", woverflow, 1);
`endif
      repeat (4) @(posedge rclk);
      @(negedge rclk);
      checkOutput("full_rempty", rempty, 0);
      checkOutput("full_rlevel", rlevel, 16);
      checkOutput("full_ralmostempty", ralmostempty, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge rclk);
         checkOutput("drain_rd", rd, i);
         checkOutput("drain_rlevel", rlevel, 16 - i);
         checkOutput("drain_ralmostempty", ralmostempty, (16 - i <= 2));
         r = 1'b1;
         @(posedge rclk);
         #1;
         r = 1'b0;
      end
      @(negedge rclk);
      checkOutput("drained_rempty", rempty, 1);
      checkOutput("drained_rd", rd, 0);
      checkOutput("drained_rlevel", rlevel, 0);
      checkOutput("drained_ralmostempty", ralmostempty, 1);
      repeat (5) @(posedge wclk);
      #1;
      checkOutput("drained_wlevel", wlevel, 0);
      checkOutput("drained_wfull", wfull, 0);
      checkOutput("drained_walmostfull", walmostfull, 0);

      // Reset with data stored discards it
      for (int i = 0; i < 8; i++) writeWord(Width'(12'h200 + i), ok);
      pulseReset();
      repeat (3) @(posedge wclk);
      repeat (3) @(posedge rclk);
      @(negedge rclk);
      checkOutput("postrst_rempty", rempty, 1);
      checkOutput("postrst_rlevel", rlevel, 0);
      checkOutput("postrst_wlevel", wlevel, 0);
      checkOutput("postrst_wfull", wfull, 0);
`ifdef AFIFO_LEVEL_ERRFLAG_EN
      checkOutput("postrst_woverflow", woverflow, 0);
`endif
      writeWord(12'h123, ok);
      readWait(data, ok);
      checkOutput("postrst_got", ok, 1);
      checkOutput("postrst_first_rd", data, 12'h123);
      @(negedge rclk);
      checkOutput("postrst_empty_again", rempty, 1);

      // Reads while empty are ignored
      @(negedge rclk);
      r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         checkOutput("underflow_rempty", rempty, 1);
         checkOutput("underflow_rlevel", rlevel, 0);
      end
      r = 1'b0;
`ifdef AFIFO_LEVEL_ERRFLAG_EN
      checkOutput("runderflow_set", runderflow, 1);
`endif
      writeWord(12'h055, ok);
      readWait(data, ok);
      checkOutput("underflow_got", ok, 1);
      checkOutput("underflow_next_rd", data, 12'h055);
`ifdef AFIFO_LEVEL_ERRFLAG_EN
      checkOutput("runderflow_sticky", runderflow, 1);
      pulseReset();
      checkOutput("runderflow_cleared", runderflow, 0);
`endif

      // Randomized data and strobes at comparable clock rates
      wHalf = 5 * Ns;
      rHalf = 7 * Ns;
      repeat (4) @(posedge rclk);
      applyStimulus(400, 1'b1, 1'b1, 1'b0);

      // Slow writer, fast reader: incrementing data and rempty latency
      wHalf = 42 * Ns;
      rHalf = 3 * Ns;
      repeat (4) @(posedge wclk);
      applyStimulus(NumStreamWords, 1'b0, 1'b0, 1'b1);

      // Fast writer, slow reader: wfull throttles the writer
      wHalf = 3 * Ns;
      rHalf = 42 * Ns;
      repeat (4) @(posedge rclk);
      applyStimulus(NumStreamWords, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
